// File: rtl/bits_pack_if.sv
// Field-in / word-out bundle for the bit packer.
// The master drives fields and flush; the slave returns packed words.
interface bits_pack_if;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flush;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  validout;

  modport master (
    output pushin, lenin, datain, flush,
    input  pushout, dataout, validout
  );

  modport slave (
    input  pushin, lenin, datain, flush,
    output pushout, dataout, validout
  );
endinterface

// File: rtl/bits_pack.sv
// Packs 0..15-bit fields LSB-first into 32-bit words with registered outputs.
// A flush that coincides with a full word defers the residual by one cycle.
module bits_pack (
  input  logic        clk,
  input  logic        rst,
  bits_pack_if.slave  bus
);
  logic [46:0] acc_q, acc_d;
  logic [5:0]  fill_q, fill_d;
  logic        flush_pend_q, flush_pend_d;
  logic        pushout_q, pushout_d;
  logic [31:0] dataout_q, dataout_d;
  logic [5:0]  validout_q, validout_d;

  logic [14:0] field;
  logic [46:0] base_acc, acc_new;
  logic [5:0]  base_fill, t;

  always_comb begin
    field     = bus.datain & ((15'd1 << bus.lenin) - 15'd1);
    // A pending residual leaves this cycle, so new bits start at bit 0.
    base_acc  = flush_pend_q ? '0 : acc_q;
    base_fill = flush_pend_q ? 6'd0 : fill_q;
    acc_new   = base_acc;
    t         = base_fill;
    if (bus.pushin && bus.lenin != 4'd0) begin
      acc_new = base_acc | ({32'd0, field} << base_fill);
      t       = base_fill + {2'b00, bus.lenin};
    end

    acc_d        = acc_new;
    fill_d       = t;
    flush_pend_d = 1'b0;
    pushout_d    = 1'b0;
    dataout_d    = dataout_q;
    validout_d   = validout_q;

    if (flush_pend_q) begin
      pushout_d    = 1'b1;
      dataout_d    = acc_q[31:0];
      validout_d   = fill_q;
      flush_pend_d = bus.flush && (t != 6'd0);
    end else if (t >= 6'd32) begin
      pushout_d    = 1'b1;
      dataout_d    = acc_new[31:0];
      validout_d   = 6'd32;
      acc_d        = {32'd0, acc_new[46:32]};
      fill_d       = t - 6'd32;
      // Only defer when there are residual bits to send.
      flush_pend_d = bus.flush && (t != 6'd32);
    end else if (bus.flush && t != 6'd0) begin
      pushout_d    = 1'b1;
      dataout_d    = acc_new[31:0];
      validout_d   = t;
      acc_d        = '0;
      fill_d       = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      pushout_q    <= 1'b0;
      dataout_q    <= '0;
      validout_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      pushout_q    <= pushout_d;
      dataout_q    <= dataout_d;
      validout_q   <= validout_d;
    end
  end

  assign bus.pushout  = pushout_q;
  assign bus.dataout  = dataout_q;
  assign bus.validout = validout_q;
endmodule
